// File: rtl/wr_ingress_pkg.sv
// Shared types for the write-ingress flush stage.
package wr_ingress_pkg;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } ingress_state_t;

endpackage

// File: rtl/ingress_fifo.sv
// Ingress buffer: DEPTH-entry FIFO using pointers with an extra wrap bit.
module ingress_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;

    // Same index with differing wrap bits means the buffer is full.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata_i;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/wr_ingress_flush.sv
// Write-ingress stage: buffers source writes, forwards them to the device,
// and answers the device's flush request with a drain and a done level.
module wr_ingress_flush
    import wr_ingress_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         src_valid_i,
    input  logic [DATA_W-1:0]            src_payload_i,
    output logic                         src_ready_o,
    output logic                         wr_valid_o,
    output logic [DATA_W-1:0]            wr_payload_o,
    input  logic                         fifo_full_i,
    input  logic                         wr_flush_i,
    output logic                         wr_done_o,
    output logic                         if_wakeup_o,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

    localparam int CW = $clog2(DEPTH+1);

    ingress_state_t state_q, state_d;
    logic           done_q, done_d;
    logic           wakeup_q, wakeup_d;
    logic           push, pop;
    logic           full, empty;
    logic [CW-1:0]  count;
    logic [CW-1:0]  occ_after;

    ingress_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push),
        .wdata_i (src_payload_i),
        .pop_i   (pop),
        .rdata_o (wr_payload_o),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // No push-through when full, even if a pop happens in the same cycle.
    assign src_ready_o = (state_q == RUN) & ~full;
    assign push        = src_valid_i & src_ready_o;
    assign wr_valid_o  = ~empty & ~fifo_full_i & (state_q != DONE);
    assign pop         = wr_valid_o;
    assign occupancy_o = count;
    assign wr_done_o   = done_q;
    assign if_wakeup_o = wakeup_q;

    // Pushes are blocked in DRAIN, so only the pop changes the count there.
    assign occ_after = count - CW'(pop);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (wr_flush_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (!wr_flush_i)          state_d = RUN;
                else if (occ_after == '0) state_d = DONE;
            end
            DONE: begin
                if (!wr_flush_i) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        done_d   = (state_d == DONE);
        wakeup_d = (state_q == DONE) & (state_d == DONE) &
                   (wakeup_q | src_valid_i);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= RUN;
            done_q   <= 1'b0;
            wakeup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            wakeup_q <= wakeup_d;
        end
    end

endmodule

// File: tb/tb_wr_ingress_flush.sv
// Directed self-checking bench for wr_ingress_flush.
module tb_wr_ingress_flush;

    logic       clk;
    logic       reset;
    logic       src_valid_i;
    logic [7:0] src_payload_i;
    logic       src_ready_o;
    logic       wr_valid_o;
    logic [7:0] wr_payload_o;
    logic       fifo_full_i;
    logic       wr_flush_i;
    logic       wr_done_o;
    logic       if_wakeup_o;
    logic [2:0] occupancy_o;

    int tests;
    int fails;

    wr_ingress_flush #(
        .DATA_W (8),
        .DEPTH  (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .src_valid_i   (src_valid_i),
        .src_payload_i (src_payload_i),
        .src_ready_o   (src_ready_o),
        .wr_valid_o    (wr_valid_o),
        .wr_payload_o  (wr_payload_o),
        .fifo_full_i   (fifo_full_i),
        .wr_flush_i    (wr_flush_i),
        .wr_done_o     (wr_done_o),
        .if_wakeup_o   (if_wakeup_o),
        .occupancy_o   (occupancy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset         = 1'b0;
        src_valid_i   = 1'b0;
        src_payload_i = 8'h00;
        fifo_full_i   = 1'b0;
        wr_flush_i    = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({wr_valid_o, wr_done_o, if_wakeup_o} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags got %b want 000",
                     {wr_valid_o, wr_done_o, if_wakeup_o});
        end
        tests++;
        if (wr_payload_o !== 8'h00 || occupancy_o !== 3'd0) begin
            fails++;
            $display("FAIL reset_data got payload=%h occ=%0d want 00/0",
                     wr_payload_o, occupancy_o);
        end
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (src_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready got %b want 1", src_ready_o);
        end
    endtask

    task automatic test_basic_push();
        logic [7:0] vals [3];
        vals[0] = 8'h11;
        vals[1] = 8'h22;
        vals[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            src_valid_i   = 1'b1;
            src_payload_i = vals[i];
            @(negedge clk);
            tests++;
            if (wr_valid_o !== 1'b1 || wr_payload_o !== vals[i]
                || occupancy_o !== 3'd1) begin
                fails++;
                $display("FAIL basic_fwd%0d got v=%b p=%h o=%0d want 1/%h/1",
                         i, wr_valid_o, wr_payload_o, occupancy_o, vals[i]);
            end
        end
        src_valid_i = 1'b0;
        @(negedge clk);
        tests++;
        if (wr_valid_o !== 1'b0 || occupancy_o !== 3'd0) begin
            fails++;
            $display("FAIL basic_empty got v=%b o=%0d want 0/0",
                     wr_valid_o, occupancy_o);
        end
    endtask

    task automatic test_full_backpressure();
        fifo_full_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            src_valid_i   = 1'b1;
            src_payload_i = 8'h41 + 8'(i);
            #1;
            tests++;
            if (src_ready_o !== (i < 4)) begin
                fails++;
                $display("FAIL full_ready%0d got %b want %b",
                         i, src_ready_o, (i < 4));
            end
            @(negedge clk);
        end
        src_valid_i = 1'b0;
        tests++;
        if (occupancy_o !== 3'd4 || wr_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL full_hold got o=%0d v=%b want 4/0",
                     occupancy_o, wr_valid_o);
        end
        fifo_full_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (wr_valid_o !== 1'b1 || wr_payload_o !== 8'h41 + 8'(i)) begin
                fails++;
                $display("FAIL full_drain%0d got v=%b p=%h want 1/%h",
                         i, wr_valid_o, wr_payload_o, 8'h41 + 8'(i));
            end
            @(negedge clk);
        end
        tests++;
        if (occupancy_o !== 3'd0 || wr_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL full_end got o=%0d v=%b want 0/0",
                     occupancy_o, wr_valid_o);
        end
    endtask

    task automatic test_flush_drain();
        fifo_full_i = 1'b1;
        src_valid_i = 1'b1;
        src_payload_i = 8'h51;
        @(negedge clk);
        src_payload_i = 8'h52;
        @(negedge clk);
        src_valid_i = 1'b0;
        fifo_full_i = 1'b0;
        wr_flush_i  = 1'b1;
        #1;
        tests++;
        if (wr_valid_o !== 1'b1 || wr_payload_o !== 8'h51) begin
            fails++;
            $display("FAIL flush_w1 got v=%b p=%h want 1/51",
                     wr_valid_o, wr_payload_o);
        end
        @(negedge clk);
        tests++;
        if (src_ready_o !== 1'b0 || wr_valid_o !== 1'b1
            || wr_payload_o !== 8'h52 || wr_done_o !== 1'b0) begin
            fails++;
            $display("FAIL flush_w2 got r=%b v=%b p=%h d=%b want 0/1/52/0",
                     src_ready_o, wr_valid_o, wr_payload_o, wr_done_o);
        end
        @(negedge clk);
        tests++;
        if (wr_done_o !== 1'b1 || wr_valid_o !== 1'b0
            || occupancy_o !== 3'd0 || src_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL flush_done got d=%b v=%b o=%0d r=%b want 1/0/0/0",
                     wr_done_o, wr_valid_o, occupancy_o, src_ready_o);
        end
        wr_flush_i = 1'b0;
        @(negedge clk);
        tests++;
        if (wr_done_o !== 1'b0 || src_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL flush_release got d=%b r=%b want 0/1",
                     wr_done_o, src_ready_o);
        end
    endtask

    task automatic test_empty_flush();
        wr_flush_i = 1'b1;
        @(negedge clk);
        tests++;
        if (wr_done_o !== 1'b0) begin
            fails++;
            $display("FAIL empty_flush_c1 got %b want 0", wr_done_o);
        end
        @(negedge clk);
        tests++;
        if (wr_done_o !== 1'b1) begin
            fails++;
            $display("FAIL empty_flush_c2 got %b want 1", wr_done_o);
        end
    endtask

    task automatic test_wakeup();
        tests++;
        if (if_wakeup_o !== 1'b0) begin
            fails++;
            $display("FAIL wake_idle got %b want 0", if_wakeup_o);
        end
        src_valid_i   = 1'b1;
        src_payload_i = 8'hA5;
        #1;
        tests++;
        if (src_ready_o !== 1'b0 || wr_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL wake_block got r=%b v=%b want 0/0",
                     src_ready_o, wr_valid_o);
        end
        @(negedge clk);
        tests++;
        if (if_wakeup_o !== 1'b1) begin
            fails++;
            $display("FAIL wake_set got %b want 1", if_wakeup_o);
        end
        @(negedge clk);
        tests++;
        if (if_wakeup_o !== 1'b1 || wr_done_o !== 1'b1) begin
            fails++;
            $display("FAIL wake_hold got w=%b d=%b want 1/1",
                     if_wakeup_o, wr_done_o);
        end
        wr_flush_i = 1'b0;
        @(negedge clk);
        tests++;
        if (if_wakeup_o !== 1'b0 || src_ready_o !== 1'b1
            || occupancy_o !== 3'd0) begin
            fails++;
            $display("FAIL wake_clear got w=%b r=%b o=%0d want 0/1/0",
                     if_wakeup_o, src_ready_o, occupancy_o);
        end
        @(negedge clk);
        src_valid_i = 1'b0;
        tests++;
        if (wr_valid_o !== 1'b1 || wr_payload_o !== 8'hA5
            || if_wakeup_o !== 1'b0) begin
            fails++;
            $display("FAIL wake_fwd got v=%b p=%h w=%b want 1/a5/0",
                     wr_valid_o, wr_payload_o, if_wakeup_o);
        end
        @(negedge clk);
        tests++;
        if (occupancy_o !== 3'd0 || wr_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL wake_end got o=%0d v=%b want 0/0",
                     occupancy_o, wr_valid_o);
        end
    endtask

    task automatic test_abort_and_reset();
        fifo_full_i   = 1'b1;
        src_valid_i   = 1'b1;
        src_payload_i = 8'h61;
        @(negedge clk);
        src_payload_i = 8'h62;
        @(negedge clk);
        src_valid_i = 1'b0;
        wr_flush_i  = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (src_ready_o !== 1'b0 || wr_done_o !== 1'b0
            || occupancy_o !== 3'd2 || wr_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL stall_drain got r=%b d=%b o=%0d v=%b want 0/0/2/0",
                     src_ready_o, wr_done_o, occupancy_o, wr_valid_o);
        end
        wr_flush_i = 1'b0;
        @(negedge clk);
        tests++;
        if (src_ready_o !== 1'b1 || occupancy_o !== 3'd2
            || wr_done_o !== 1'b0) begin
            fails++;
            $display("FAIL abort got r=%b o=%0d d=%b want 1/2/0",
                     src_ready_o, occupancy_o, wr_done_o);
        end
        wr_flush_i = 1'b1;
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        tests++;
        if (occupancy_o !== 3'd0 || wr_valid_o !== 1'b0
            || wr_done_o !== 1'b0 || if_wakeup_o !== 1'b0
            || wr_payload_o !== 8'h00) begin
            fails++;
            $display("FAIL async_rst got o=%0d v=%b d=%b w=%b p=%h want 0/0/0/0/00",
                     occupancy_o, wr_valid_o, wr_done_o, if_wakeup_o,
                     wr_payload_o);
        end
        wr_flush_i  = 1'b0;
        fifo_full_i = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (src_ready_o !== 1'b1 || occupancy_o !== 3'd0
            || wr_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL post_rst got r=%b o=%0d v=%b want 1/0/0",
                     src_ready_o, occupancy_o, wr_valid_o);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic_push();
        test_full_backpressure();
        test_flush_drain();
        test_empty_flush();
        test_wakeup();
        test_abort_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
